// File: rtl/lsu_pkg.sv
// Shared opcodes, FSM state type and queue entry layout for the lane-4 load/store sequencer.
package lsu_pkg;

    localparam int unsigned LSU_ADDR_W = 32;
    localparam int unsigned LSU_DATA_W = 32;
    localparam int unsigned LSU_TAG_W  = 5;

    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } lsu_state_t;

    // Queued instruction; field widths are the sequencer's default port widths.
    typedef struct packed {
        logic                  we;
        logic [LSU_ADDR_W-1:0] addr;
        logic [LSU_DATA_W-1:0] wdata;
        logic [LSU_TAG_W-1:0]  tag;
    } lsu_entry_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/lsu_fifo.sv
// In-order instruction queue: synchronous FIFO with clear, power-of-two depth, wrapping pointers.
module lsu_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full refuses a push even when a pop happens in the same cycle.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lsu_sequencer.sv
// Lane-4 load/store sequencer: queues memory ops and drives the single data-memory port,
// returning load results to writeback as a tagged one-cycle pulse.
module lsu_sequencer
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W,
    parameter int unsigned DATA_W = LSU_DATA_W,
    parameter int unsigned TAG_W  = LSU_TAG_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [3:0]        issue_op,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] issue_wdata,
    input  logic [TAG_W-1:0]  issue_tag,
    output logic              issue_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    lsu_entry_t       push_entry;
    lsu_entry_t       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    lsu_state_t       state;
    logic             kill;
    logic [TAG_W-1:0] hold_tag;

    assign push        = issue_valid && is_mem_op(issue_op) && !flush;
    assign pop         = (state == IDLE) && !fifo_empty && !flush;
    assign issue_ready = !fifo_full;
    assign busy        = (count != '0) || (state != IDLE);

    always_comb begin
        push_entry       = '0;
        push_entry.we    = (issue_op == OP_STORE);
        push_entry.addr  = LSU_ADDR_W'(issue_addr);
        push_entry.wdata = LSU_DATA_W'(issue_wdata);
        push_entry.tag   = LSU_TAG_W'(issue_tag);
    end

    lsu_fifo #(
        .WIDTH ($bits(lsu_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    // Port FSM; mem_we/mem_addr/mem_wdata plus hold_tag form the hold register for the op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            kill      <= 1'b0;
            hold_tag  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_tag    <= '0;
            wb_data   <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= head.we;
                        mem_addr  <= ADDR_W'(head.addr);
                        mem_wdata <= DATA_W'(head.wdata);
                        hold_tag  <= TAG_W'(head.tag);
                    end
                end
                REQ: begin
                    // The request is never withdrawn; a flush only marks a load result as dead.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state <= IDLE;
                            kill  <= 1'b0;
                        end else begin
                            state    <= WB;
                            wb_valid <= !(kill || flush);
                            wb_tag   <= hold_tag;
                            wb_data  <= mem_rdata;
                            kill     <= kill || flush;
                        end
                    end else if (flush) begin
                        kill <= 1'b1;
                    end
                end
                WB: begin
                    state <= IDLE;
                    kill  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Self-checking bench for lsu_sequencer: transaction-level reference model, directed table,
// hand-written multi-cycle sequences and randomized traffic.
module tb_lsu_sequencer;
    import lsu_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              issue_valid = 1'b0;
    logic [3:0]        issue_op = 4'b0;
    logic [ADDR_W-1:0] issue_addr = '0;
    logic [DATA_W-1:0] issue_wdata = '0;
    logic [TAG_W-1:0]  issue_tag = '0;
    logic              issue_ready;
    logic              flush = 1'b0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;
    logic              busy;

    always #5 clk = ~clk;

    lsu_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_addr  (issue_addr),
        .issue_wdata (issue_wdata),
        .issue_tag   (issue_tag),
        .issue_ready (issue_ready),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .wb_data     (wb_data),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents seen by the responder: a fixed scramble of the address.
    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'hDEADBFEF;
    endfunction

    // ---------------- reference model (queue + port occupancy) ----------------
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  tag;
    } instr_t;

    instr_t      mq[$];
    instr_t      cur;
    bit          on_bus   = 1'b0;
    bit          wb_slot  = 1'b0;
    bit          m_kill   = 1'b0;
    bit          m_req    = 1'b0;
    bit          m_we     = 1'b0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    bit          m_wbv    = 1'b0;
    logic [4:0]  m_wbtag  = '0;
    logic [31:0] m_wbdata = '0;

    always @(posedge clk or negedge rst_n) begin
        bit take;
        if (!rst_n) begin
            mq.delete();
            on_bus = 0; wb_slot = 0; m_kill = 0; m_req = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_wbv = 0; m_wbtag = '0; m_wbdata = '0;
        end else begin
            take = issue_valid && (issue_op == OP_LOAD || issue_op == OP_STORE)
                   && !flush && (mq.size() < DEPTH);
            m_wbv = 0;
            if (wb_slot) begin
                wb_slot = 0;
                m_kill  = 0;
            end else if (on_bus) begin
                if (flush) m_kill = 1;
                if (mem_ack) begin
                    on_bus = 0;
                    m_req  = 0;
                    if (cur.we) m_kill = 0;
                    else begin
                        wb_slot  = 1;
                        m_wbv    = !m_kill;
                        m_wbtag  = cur.tag;
                        m_wbdata = rdata_of(cur.addr);
                    end
                end
            end else if (mq.size() != 0 && !flush) begin
                cur = mq.pop_front();
                on_bus = 1; m_req = 1; m_we = cur.we; m_addr = cur.addr; m_wdata = cur.wdata;
            end
            if (flush) mq.delete();
            if (take) mq.push_back('{we: (issue_op == OP_STORE), addr: issue_addr,
                                     wdata: issue_wdata, tag: issue_tag});
        end
    end

    // ---------------- per-cycle checker and memory responder ----------------
    typedef struct {
        bit          we;
        logic [31:0] addr;
    } bus_t;

    bus_t bus_log[$];
    int   ack_delay  = 0;
    int   wait_cnt   = 0;
    bit   rand_delay = 1'b0;

    always @(negedge clk) begin
        check("issue_ready", 32'(issue_ready), 32'(mq.size() < DEPTH));
        check("busy", 32'(busy), 32'(mq.size() != 0 || on_bus || wb_slot));
        check("mem_req", 32'(mem_req), 32'(m_req));
        if (m_req) begin
            check("mem_we", 32'(mem_we), 32'(m_we));
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
        end
        check("wb_valid", 32'(wb_valid), 32'(m_wbv));
        if (m_wbv) begin
            check("wb_tag", 32'(wb_tag), 32'(m_wbtag));
            check("wb_data", wb_data, m_wbdata);
        end
        if (!rst_n) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata_of(mem_addr);
                bus_log.push_back('{we: mem_we, addr: mem_addr});
                wait_cnt  = 0;
                if (rand_delay) ack_delay = $urandom_range(0, 3);
            end else begin
                wait_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] t);
        issue_valid = v;
        issue_op    = op;
        issue_addr  = a;
        issue_wdata = d;
        issue_tag   = t;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        check({tag, "_wb_tag"}, 32'(wb_tag), 32'd0);
        check({tag, "_wb_data"}, wb_data, 32'd0);
        check({tag, "_issue_ready"}, 32'(issue_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  tag;
        int          delay;
        int          exp_req;
        int          exp_wb_k;
        logic [31:0] exp_data;
    } vec_t;

    initial begin
        vec_t        vecs[8];
        int          req_n, wb_n, wb_k, first_low, guard;
        bit          busy_any;
        logic [3:0]  ops[6];

        ops = '{OP_LOAD, OP_STORE, OP_LOAD, OP_STORE, 4'b0001, 4'b1111};
        vecs[0] = '{OP_LOAD,  32'h0000_0100, 32'h0,          5'd7,  0, 1,  2, 32'hDEAD_BEEF};
        vecs[1] = '{OP_STORE, 32'h0000_0200, 32'h1234_5678,  5'd0,  0, 1, -1, 32'h0};
        vecs[2] = '{4'b0001,  32'h0000_0300, 32'h0,          5'd3,  0, 0, -1, 32'h0};
        vecs[3] = '{OP_LOAD,  32'h2000_0040, 32'h0,          5'd31, 1, 2,  3, 32'hFEAD_BFAF};
        vecs[4] = '{OP_STORE, 32'h0000_0044, 32'hCAFE_F00D,  5'd0,  2, 3, -1, 32'h0};
        vecs[5] = '{4'b0000,  32'h0000_0500, 32'h0,          5'd1,  0, 0, -1, 32'h0};
        vecs[6] = '{4'b0110,  32'h0000_0600, 32'h0,          5'd2,  0, 0, -1, 32'h0};
        vecs[7] = '{OP_LOAD,  32'h0000_0000, 32'h0,          5'd1,  0, 1,  2, 32'hDEAD_BFEF};

        // Reset state, both during and just after reset.
        step();
        check_reset_outputs("in_reset");
        step();
        rst_n = 1'b1;
        step();
        check_reset_outputs("post_reset");

        // Directed single-instruction table from an idle sequencer.
        for (int i = 0; i < 8; i++) begin
            ack_delay = vecs[i].delay;
            drive(1, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].tag);
            step();
            drive(0, 4'b0, 32'h0, 32'h0, 5'd0);
            req_n = 0; wb_n = 0; wb_k = -1; busy_any = 0;
            for (int k = 0; k < 10; k++) begin
                if (k > 0) step();
                if (mem_req) req_n++;
                if (busy) busy_any = 1;
                if (wb_valid) begin
                    wb_n++;
                    if (wb_k < 0) begin
                        wb_k = k;
                        check($sformatf("vec%0d_wb_tag", i), 32'(wb_tag), 32'(vecs[i].tag));
                        check($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].exp_data);
                    end
                end
            end
            check($sformatf("vec%0d_req_cycles", i), 32'(req_n), 32'(vecs[i].exp_req));
            check($sformatf("vec%0d_wb_cycle", i), 32'(wb_k), 32'(vecs[i].exp_wb_k));
            check($sformatf("vec%0d_wb_pulses", i), 32'(wb_n), 32'(vecs[i].exp_wb_k >= 0));
            check($sformatf("vec%0d_busy_seen", i), 32'(busy_any), 32'(vecs[i].exp_req > 0));
            check($sformatf("vec%0d_idle_end", i), 32'(busy), 32'd0);
        end

        // Back-to-back stores with slow acks: the queue fills and a store is held off.
        ack_delay = 2;
        bus_log.delete();
        first_low = -1;
        wb_n = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, OP_STORE, 32'h1000 + 32'(i * 4), 32'hA000 + 32'(i), 5'd0);
            guard = 0;
            while (!issue_ready && guard < 20) begin
                if (first_low < 0) first_low = i;
                if (wb_valid) wb_n++;
                step();
                guard++;
            end
            if (wb_valid) wb_n++;
            step();
        end
        drive(0, 4'b0, 32'h0, 32'h0, 5'd0);
        for (int k = 0; k < 40 && busy; k++) begin
            if (wb_valid) wb_n++;
            step();
        end
        check("burst_first_refused", 32'(first_low), 32'd5);
        check("burst_drained", 32'(busy), 32'd0);
        check("burst_bus_count", 32'(bus_log.size()), 32'd6);
        check("burst_no_wb", 32'(wb_n), 32'd0);
        for (int i = 0; i < 6 && i < bus_log.size(); i++) begin
            check($sformatf("burst_order%0d", i), bus_log[i].addr, 32'h1000 + 32'(i * 4));
        end

        // Flush while a load is on the bus with two stores queued behind it.
        ack_delay = 4;
        bus_log.delete();
        wb_n = 0;
        drive(1, OP_LOAD, 32'h0000_0300, 32'h0, 5'd3);
        step();
        drive(1, OP_STORE, 32'h0000_0310, 32'h11, 5'd0);
        step();
        drive(1, OP_STORE, 32'h0000_0314, 32'h22, 5'd0);
        step();
        check("flush_pre_req", 32'(mem_req), 32'd1);
        flush = 1'b1;
        drive(1, OP_STORE, 32'h0000_0318, 32'h33, 5'd0);
        step();
        flush = 1'b0;
        drive(0, 4'b0, 32'h0, 32'h0, 5'd0);
        check("flush_busy_held", 32'(busy), 32'd1);
        check("flush_req_held", 32'(mem_req), 32'd1);
        for (int k = 0; k < 20 && busy; k++) begin
            if (wb_valid) wb_n++;
            step();
        end
        for (int k = 0; k < 4; k++) begin
            if (wb_valid) wb_n++;
            step();
        end
        check("flush_idle", 32'(busy), 32'd0);
        check("flush_no_wb", 32'(wb_n), 32'd0);
        check("flush_bus_count", 32'(bus_log.size()), 32'd1);
        if (bus_log.size() > 0) check("flush_bus_addr", bus_log[0].addr, 32'h0000_0300);

        // Asynchronous reset in the middle of a request.
        ack_delay = 6;
        drive(1, OP_LOAD, 32'h0000_0400, 32'h0, 5'd9);
        step();
        drive(0, 4'b0, 32'h0, 32'h0, 5'd0);
        step();
        check("rst_pre_req", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        step();
        step();
        rst_n = 1'b1;
        ack_delay = 0;
        step();
        check_reset_outputs("after_abort");

        // Randomized traffic with flushes and variable ack latency.
        rand_delay = 1'b1;
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 10) < 6, ops[$urandom % 6], $urandom & 32'hFFFF_FFFC,
                  $urandom, 5'($urandom));
            flush = (($urandom % 20) == 0);
            step();
        end
        drive(0, 4'b0, 32'h0, 32'h0, 5'd0);
        flush = 1'b0;
        for (int k = 0; k < 80 && busy; k++) step();
        check("random_drain", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
